// File: rtl/div_pkg.sv
// Shared definitions for the 4-bit restoring divider: widths, step count and FSM encoding.
package div_pkg;

   localparam int unsigned DIV_W     = 4;
   localparam int unsigned DIV_STEPS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // A trial subtraction succeeds when the shifted partial remainder already
   // exceeds 15 (its top bit is set) or when the 4-bit subtraction does not borrow.
   function automatic logic step_ok(input logic s_msb, input logic bout);
      return s_msb | ~bout;
   endfunction

endpackage

// File: rtl/restoring_divider_4bit_if.sv
// Start/done handshake and operand/result bundle between the lab top level and the divider.
interface restoring_divider_4bit_if;
   import div_pkg::*;

   logic             start;
   logic [DIV_W-1:0] dividend;
   logic [DIV_W-1:0] divisor;
   logic             busy;
   logic             done;
   logic [DIV_W-1:0] quotient;
   logic [DIV_W-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/bls_sub4.sv
// 4-bit borrow-lookahead subtractor: Diff = X - Y - Bin, Bout set when the result underflows.
module bls_sub4 (
   input  logic [3:0] X,
   input  logic [3:0] Y,
   input  logic       Bin,
   output logic [3:0] Diff,
   output logic       Bout
);

   logic [3:0] g_s;   // borrow generate: X bit 0, Y bit 1
   logic [3:0] p_s;   // borrow propagate: X bit equals Y bit
   logic [4:0] b_s;   // borrow into each bit position, b_s[4] is the borrow out

   assign g_s = ~X & Y;
   assign p_s = ~(X ^ Y);

   // Every borrow is expanded directly from the generate/propagate terms so no
   // ripple chain exists between bit positions.
   assign b_s[0] = Bin;
   assign b_s[1] = g_s[0]
                 | (p_s[0] & Bin);
   assign b_s[2] = g_s[1]
                 | (p_s[1] & g_s[0])
                 | (p_s[1] & p_s[0] & Bin);
   assign b_s[3] = g_s[2]
                 | (p_s[2] & g_s[1])
                 | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & Bin);
   assign b_s[4] = g_s[3]
                 | (p_s[3] & g_s[2])
                 | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Bin);

   assign Diff = X ^ Y ^ b_s[3:0];
   assign Bout = b_s[4];

endmodule

// File: rtl/restoring_divider_4bit.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per cycle from a
// single borrow-lookahead subtractor slice, driven by an IDLE/RUN/DONE FSM.
module restoring_divider_4bit
   import div_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   restoring_divider_4bit_if.slave  bus
);

   div_state_e       state_r;
   div_state_e       next_state_s;
   logic [1:0]       count_r;
   logic [DIV_W-1:0] q_r;
   // Partial remainder. Its fifth bit is structurally zero after every step: a
   // successful subtraction stores {0, Diff}, and a failed one can only occur
   // when the shifted value is below 16, so only the low four bits are kept.
   logic [DIV_W-1:0] r_r;
   logic [DIV_W-1:0] d_r;
   logic [DIV_W-1:0] quotient_r;
   logic [DIV_W-1:0] remainder_r;
   logic             dbz_r;
   logic             busy_r;
   logic             done_r;
   logic             busy_nxt_s;
   logic             done_nxt_s;

   logic             accept_s;
   logic             last_step_s;
   logic [DIV_W:0]   s_s;
   logic [DIV_W-1:0] diff_s;
   logic             bout_s;
   logic             ok_s;
   logic [DIV_W-1:0] r_step_s;
   logic [DIV_W-1:0] q_step_s;

   assign accept_s    = (state_r == IDLE) && bus.start;
   assign last_step_s = (count_r == 2'(DIV_STEPS - 1));

   // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
   assign s_s = {r_r, q_r[DIV_W-1]};

   bls_sub4 u_sub (
      .X    (s_s[DIV_W-1:0]),
      .Y    (d_r),
      .Bin  (1'b0),
      .Diff (diff_s),
      .Bout (bout_s)
   );

   assign ok_s     = step_ok(s_s[DIV_W], bout_s);
   assign r_step_s = ok_s ? diff_s : s_s[DIV_W-1:0];
   assign q_step_s = {q_r[DIV_W-2:0], ok_s};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: a zero divisor skips RUN and completes immediately.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == 4'd0) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_step_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode from the next state so busy/done come out of flops aligned with the state.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (next_state_s)
         IDLE: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
         RUN: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b0;
         end
         DONE: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   // Operand latch, per-step Q/R update, step counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_r         <= 4'd0;
         q_r         <= 4'd0;
         r_r         <= 4'd0;
         count_r     <= 2'd0;
         quotient_r  <= 4'd0;
         remainder_r <= 4'd0;
         dbz_r       <= 1'b0;
      end else if (accept_s) begin
         d_r     <= bus.divisor;
         q_r     <= bus.dividend;
         r_r     <= 4'd0;
         count_r <= 2'd0;
         if (bus.divisor == 4'd0) begin
            quotient_r  <= 4'hF;
            remainder_r <= bus.dividend;
            dbz_r       <= 1'b1;
         end else begin
            dbz_r <= 1'b0;
         end
      end else if (state_r == RUN) begin
         q_r     <= q_step_s;
         r_r     <= r_step_s;
         count_r <= count_r + 2'd1;
         if (last_step_s) begin
            quotient_r  <= q_step_s;
            remainder_r <= r_step_s;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Directed self-checking bench for restoring_divider_4bit.
module tb_restoring_divider_4bit;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   restoring_divider_4bit_if bus ();

   restoring_divider_4bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start a division at the next negedge, optionally disturb inputs during RUN,
   // and check latency, busy length and results. Returns at the done negedge.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int elat, input int ebusy, input bit disturb,
                          input string tag);
      int busy_n;
      int done_at;
      busy_n  = 0;
      done_at = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin
            done_at = n;
            break;
         end
         if (disturb && n == 2) begin
            bus.start    = 1'b1;
            bus.dividend = 4'd1;
            bus.divisor  = 4'd1;
         end
         if (disturb && n == 3) begin
            bus.start = 1'b0;
         end
      end
      check({tag, " latency"}, 32'(done_at), 32'(elat));
      check({tag, " busy_cycles"}, 32'(busy_n), 32'(ebusy));
      check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
      check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
      check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
   endtask

   initial begin
      int done_seen;
      logic [3:0] eq;
      logic [3:0] er;
      tests        = 0;
      fails        = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = 4'd0;
      bus.divisor  = 4'd0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst quotient", 32'(bus.quotient), 32'd0);
      check("rst remainder", 32'(bus.remainder), 32'd0);
      check("rst div_by_zero", 32'(bus.div_by_zero), 32'd0);
      rst_n = 1'b1;

      // Directed divisions.
      run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, 4, 1'b0, "13/3");
      run_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5, 4, 1'b0, "15/1");
      run_div(4'd2,  4'd9,  4'd0,  4'd2, 1'b0, 5, 4, 1'b0, "2/9");
      run_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, 4, 1'b0, "15/15");
      run_div(4'd7,  4'd0,  4'hF,  4'd7, 1'b1, 1, 0, 1'b0, "7/0");
      // start 1/1 and operand change during RUN must not disturb 13/3.
      run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, 4, 1'b1, "13/3 disturbed");

      // Reset asserted in the second RUN cycle.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 4'd13;
      bus.divisor  = 4'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort quotient", 32'(bus.quotient), 32'd0);
      check("abort remainder", 32'(bus.remainder), 32'd0);
      check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      check("abort no_done", 32'(done_seen), 32'd0);
      run_div(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, 4, 1'b0, "9/2 after abort");

      // Exhaustive back-to-back sweep against a reference model.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               run_div(4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1, 0, 1'b0,
                       $sformatf("sweep %0d/%0d", a, b));
            end else begin
               eq = 4'(a / b);
               er = 4'(a % b);
               run_div(4'(a), 4'(b), eq, er, 1'b0, 5, 4, 1'b0,
                       $sformatf("sweep %0d/%0d", a, b));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
